// File: rtl/uart_now_pkg.sv
// Shared types and widths for the UART transmit feeder path.
package uart_now_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_ACT  = 2'd2,
        S_WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty/count flags and a sticky overflow bit.
module uart_byte_fifo
    import uart_now_pkg::*;
#(
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [UART_BYTE_W-1:0] rd_data,
    input  logic                   ovf_clr,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       count,
    output logic                   overflow
);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   ovf_q, ovf_d;
    logic                   wr_fire_c;
    logic                   rd_fire_c;

    // Flags act on last cycle's registered state, so a write while full is dropped
    // even when a pop happens in the same cycle.
    assign wr_fire_c = wr_en && !full_q;
    assign rd_fire_c = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (wr_fire_c) begin
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
        if (rd_fire_c) begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
        // Extra pointer MSB makes the difference range 0..DEPTH without aliasing.
        count_d = wr_ptr_d - rd_ptr_d;
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them one at a time into uart_tx, pacing on its
// active/done handshake.
module uart_tx_feeder
    import uart_now_pkg::*;
#(
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_En,
    input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [ADDR_W:0]        o_Count,
    output logic                   o_Overflow,
    input  logic                   i_Ovf_Clr,
    output logic                   o_Tx_DV,
    output logic [UART_BYTE_W-1:0] o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done
);

    feeder_state_t          state_q, state_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic [UART_BYTE_W-1:0] fifo_rd_data;
    logic                   pop_c;

    uart_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .wr_en    (i_Wr_En),
        .wr_data  (i_Wr_Byte),
        .rd_en    (pop_c),
        .rd_data  (fifo_rd_data),
        .ovf_clr  (i_Ovf_Clr),
        .full     (o_Full),
        .empty    (o_Empty),
        .count    (o_Count),
        .overflow (o_Overflow)
    );

    // uart_tx is never reset, so an abandoned frame is waited out via its active flag.
    assign pop_c = (state_q == S_IDLE) && !o_Empty && !i_Tx_Active;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (i_Tx_Active) begin
                    state_d = S_WAIT_DONE;
                end else if (i_Tx_Done) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Launch strobe is high exactly while the FSM sits in S_LAUNCH.
    always_comb begin
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        if (pop_c) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = fifo_rd_data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign o_Tx_DV   = tx_dv_q;
    assign o_Tx_Byte = tx_byte_q;

endmodule
